noc_flit_deserializer: RTL and testbench
========================================

# noc_flit_deserializer

Single-clock receive endpoint on the NoC side of the ring. It takes flits from a router output port under credit-based flow control and buffers them in a local flit FIFO. It returns one credit per flit consumed, reassembles `SERIALIZATION_FACTOR` flits into one AXI-Stream beat, and presents that beat to the user logic. It is the receive-side counterpart of the flit serializer used on router inputs, and is used where NoC and user logic share `clk`.

## Interface
Parameters:
- `TDEST_WIDTH`, 6: destination/ID field carried with every flit; for ring endpoints this is TID+TDEST.
- `TDATA_WIDTH`, 512: width of the reassembled AXIS beat.
- `SERIALIZATION_FACTOR`, 4: number of flits per beat; must be ≥1 and divide `TDATA_WIDTH`.
- `FLIT_BUFFER_DEPTH`, 4: local FIFO depth; must equal the sender's initial credit count; ≥2.
- `FLIT_WIDTH`, derived as `TDATA_WIDTH/SERIALIZATION_FACTOR`; localparam.

Ports:
- `clk` in 1: sole clock.
- `rst` in 1: reset, **synchronous, active-high**.
- `data_in` in `FLIT_WIDTH`: flit payload.
- `dest_in` in `TDEST_WIDTH`: flit destination/ID.
- `is_tail_in` in 1: flit is the last flit of a packet.
- `send_in` in 1: flit valid; qualifies the three inputs above for one cycle.
- `credit_out` out 1: one-cycle pulse; one pulse per flit freed from the FIFO.
- `axis_tvalid` out 1.
- `axis_tready` in 1.
- `axis_tdata` out `TDATA_WIDTH`.
- `axis_tlast` out 1.
- `axis_tdest` out `TDEST_WIDTH`.
- `err_overflow` out 1: sticky protocol error (see Configuration).

## Operation
- **Flit FIFO.**
  - `send_in=1` writes {data, dest, tail} at the clock edge.
  - Storage is `FLIT_BUFFER_DEPTH` entries with a wrap-around read/write pointer.
  - Occupancy counter width is `$clog2(FLIT_BUFFER_DEPTH+1)`.
  - A simultaneous write and pop leaves occupancy unchanged.
- **Assembly.**
  - An index counter runs 0..SF-1. A pop writes the flit into slice `[idx*FLIT_WIDTH +: FLIT_WIDTH]`, so flit 0 lands in the LSBs.
  - The `dest` of flit idx=0 is latched as the beat's tdest.
  - A beat is complete at idx=SF-1 or on a tail flit.
  - On a tail flit with idx<SF-1 (short beat), the unfilled upper slices read zero.
  - On completion, idx returns to 0.
- **Pop rule.** Pop when the FIFO is non-empty AND NOT (the popped flit completes a beat AND the output register is held, i.e. `axis_tvalid && !axis_tready`).
- **Output register.**
  - A completed beat moves into the output register in the same edge and sets `axis_tvalid`.
  - `axis_tlast` is the tail bit of the completing flit.
  - Output stays stable while `axis_tvalid && !axis_tready`.
  - Assembly of the next beat continues while the output is held, up to the completing flit.
- **Credit.** `credit_out` is registered and equals the pop signal of the previous cycle.
- **Reset.**
  - Pointers, occupancy and idx are cleared; assembly contents are discarded.
  - Outputs reset to: `axis_tvalid`=0, `axis_tlast`=0, `axis_tdata`=0, `axis_tdest`=0, `credit_out`=0, `err_overflow`=0.
  - Flits buffered at reset return no credit; the sender shares `rst` and restores its full credit count itself.
  - A `send_in` in a reset cycle is ignored.

## Timing
- `send_in` at cycle N → FIFO entry visible N+1 → earliest pop N+1 → `credit_out` at N+2.
- With SF=1, `axis_tvalid` rises at N+2.
- With SF>1 and back-to-back flits from N, `axis_tvalid` rises at N+SF+1.
- Sustained throughput is one flit per cycle and one beat per SF cycles, with `axis_tready` held high.
- Stall: while the output is held and a completing flit waits, pops stop and credits stop. FIFO-full is prevented by the sender's credits.
- Output handshake: a transfer occurs when `axis_tvalid && axis_tready`. If a new beat completes in the same cycle, `axis_tvalid` stays 1 with the new data; there is no bubble.

## Configuration
- `NOC_DESER_OVERFLOW_CHECK_EN` defined:
  - `err_overflow` is set on `send_in` while occupancy == `FLIT_BUFFER_DEPTH` and no pop occurs that cycle.
  - The offending flit is dropped; FIFO contents are untouched.
  - The flag stays set until `rst`.
- Not defined:
  - `err_overflow` is tied 0.
  - There is no full check, so overflow behaviour is undefined; the credit protocol guarantees it never occurs.

## Test plan
- SF=4, single 4-flit packet of data 0x11,0x22,0x33,0x44 sent back-to-back, last flit tail, `axis_tready`=1 → one beat with slices {0x44,0x33,0x22,0x11} MSB→LSB, tlast=1, tdest from flit 0; exactly 4 `credit_out` pulses, the first at N+2.
- SF=4, tail on flit 2 → beat with upper slice 0, tlast=1; the next packet's flit 0 lands in slice 0.
- `axis_tready`=0 for 20 cycles while 8 flits are sent, with DEPTH=4 sender credit honoured → at most 4+3 flits popped and credits stop. After ready rises, both beats are delivered in order with no bubble between them.
- Random `axis_tready` (50%), 1000 flits, sender model enforcing credits → scoreboard matches all data/dest/tlast, and the credit total equals the flit count.
- `rst` asserted mid-packet with 3 flits buffered → all outputs return to reset values the next cycle and no stale flit appears afterward.
- With `NOC_DESER_OVERFLOW_CHECK_EN` defined, a 5th `send_in` into a full DEPTH=4 FIFO with output stalled → `err_overflow`=1 the next cycle and held; FIFO contents unchanged.

Source files
------------

// File: rtl/noc_flit_deserializer.sv
// Credit-flow flit FIFO feeding an SF:1 flit-to-AXI-Stream reassembler.
// Optional overflow detection: define NOC_DESER_OVERFLOW_CHECK_EN.
module noc_flit_deserializer #(
  parameter int TDEST_WIDTH = 6,
  parameter int TDATA_WIDTH = 512,
  parameter int SERIALIZATION_FACTOR = 4,
  parameter int FLIT_BUFFER_DEPTH = 4,
  localparam int FLIT_WIDTH = TDATA_WIDTH / SERIALIZATION_FACTOR
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [FLIT_WIDTH-1:0]  data_in,
  input  logic [TDEST_WIDTH-1:0] dest_in,
  input  logic                   is_tail_in,
  input  logic                   send_in,
  output logic                   credit_out,
  output logic                   axis_tvalid,
  input  logic                   axis_tready,
  output logic [TDATA_WIDTH-1:0] axis_tdata,
  output logic                   axis_tlast,
  output logic [TDEST_WIDTH-1:0] axis_tdest,
  output logic                   err_overflow
);

  localparam int SF    = SERIALIZATION_FACTOR;
  localparam int DEPTH = FLIT_BUFFER_DEPTH;
  localparam int PW    = $clog2(DEPTH);
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int IW    = (SF > 1) ? $clog2(SF) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(SF - 1);
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

  logic [FLIT_WIDTH-1:0]  mem_data [DEPTH];
  logic [TDEST_WIDTH-1:0] mem_dest [DEPTH];
  logic [DEPTH-1:0]       mem_tail;

  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;

  logic [TDATA_WIDTH-1:0] asm_q, asm_d, beat;
  logic [TDEST_WIDTH-1:0] adest_q, adest_d, beat_dest;

  logic                   vld_q, vld_d;
  logic                   last_q, last_d;
  logic [TDATA_WIDTH-1:0] data_q, data_d;
  logic [TDEST_WIDTH-1:0] dest_q, dest_d;
  logic                   cred_q;

  logic wr, pop, head_tail, done, held;

`ifdef NOC_DESER_OVERFLOW_CHECK_EN
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  logic err_q, err_d, drop;
`endif

  always_comb begin
    head_tail = mem_tail[rptr_q];
    held      = vld_q && !axis_tready;
    done      = (idx_q == IDX_LAST) || head_tail;
    pop       = (cnt_q != '0) && !(done && held);
`ifdef NOC_DESER_OVERFLOW_CHECK_EN
    drop  = send_in && (cnt_q == CNT_FULL) && !pop;
    err_d = err_q || drop;
    wr    = send_in && !drop;
`else
    wr    = send_in;
`endif

    // Current flit merged into its slice; never-written upper slices stay 0
    beat = asm_q;
    for (int i = 0; i < SF; i++) begin
      if (idx_q == IW'(i)) begin
        beat[i*FLIT_WIDTH +: FLIT_WIDTH] = mem_data[rptr_q];
      end
    end
    beat_dest = (idx_q == '0) ? mem_dest[rptr_q] : adest_q;

    wptr_d = wptr_q;
    if (wr) wptr_d = (wptr_q == PTR_LAST) ? '0 : wptr_q + 1'b1;
    rptr_d = rptr_q;
    if (pop) rptr_d = (rptr_q == PTR_LAST) ? '0 : rptr_q + 1'b1;
    cnt_d = cnt_q + CW'(wr) - CW'(pop);

    idx_d   = idx_q;
    asm_d   = asm_q;
    adest_d = adest_q;
    vld_d   = vld_q && !axis_tready;
    data_d  = data_q;
    dest_d  = dest_q;
    last_d  = last_q;
    if (pop) begin
      if (done) begin
        idx_d  = '0;
        asm_d  = '0;
        vld_d  = 1'b1;
        data_d = beat;
        dest_d = beat_dest;
        last_d = head_tail;
      end else begin
        idx_d   = idx_q + 1'b1;
        asm_d   = beat;
        adest_d = beat_dest;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr && !rst) begin
      mem_data[wptr_q] <= data_in;
      mem_dest[wptr_q] <= dest_in;
      mem_tail[wptr_q] <= is_tail_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      asm_q   <= '0;
      adest_q <= '0;
      vld_q   <= 1'b0;
      data_q  <= '0;
      dest_q  <= '0;
      last_q  <= 1'b0;
      cred_q  <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      asm_q   <= asm_d;
      adest_q <= adest_d;
      vld_q   <= vld_d;
      data_q  <= data_d;
      dest_q  <= dest_d;
      last_q  <= last_d;
      cred_q  <= pop;
    end
  end

`ifdef NOC_DESER_OVERFLOW_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end
  assign err_overflow = err_q;
`else
  assign err_overflow = 1'b0;
`endif

  assign credit_out  = cred_q;
  assign axis_tvalid = vld_q;
  assign axis_tdata  = data_q;
  assign axis_tlast  = last_q;
  assign axis_tdest  = dest_q;

endmodule

// File: tb/tb_noc_flit_deserializer.sv
// Bench for noc_flit_deserializer: credit-honouring sender, beat-level
// reference model and scoreboard, directed timing/stall/reset cases.
module tb_noc_flit_deserializer;

  localparam int TDW   = 6;
  localparam int TDA   = 512;
  localparam int SF    = 4;
  localparam int DEPTH = 4;
  localparam int FW    = TDA / SF;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [FW-1:0]  data_in = '0;
  logic [TDW-1:0] dest_in = '0;
  logic           is_tail_in = 1'b0;
  logic           send_in = 1'b0;
  logic           credit_out;
  logic           axis_tvalid;
  logic           axis_tready = 1'b0;
  logic [TDA-1:0] axis_tdata;
  logic           axis_tlast;
  logic [TDW-1:0] axis_tdest;
  logic           err_overflow;

  always #5 clk = ~clk;

  noc_flit_deserializer #(
    .TDEST_WIDTH(TDW),
    .TDATA_WIDTH(TDA),
    .SERIALIZATION_FACTOR(SF),
    .FLIT_BUFFER_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .data_in(data_in),
    .dest_in(dest_in),
    .is_tail_in(is_tail_in),
    .send_in(send_in),
    .credit_out(credit_out),
    .axis_tvalid(axis_tvalid),
    .axis_tready(axis_tready),
    .axis_tdata(axis_tdata),
    .axis_tlast(axis_tlast),
    .axis_tdest(axis_tdest),
    .err_overflow(err_overflow)
  );

  typedef struct packed {
    logic [TDA-1:0] d;
    logic [TDW-1:0] t;
    logic           l;
  } beat_t;

  beat_t expq[$];
  beat_t rx_log[$];

  logic [TDA-1:0] cur_d = '0;
  logic [TDW-1:0] cur_t = '0;
  int cur_n = 0;

  int n_vec = 0;
  int n_fail = 0;
  int cyc = 0;
  int credits = DEPTH;
  int cred_cnt = 0;
  int first_cred = -1;
  int first_val = -1;
  int rdy_mode = 0;
  logic exp_err = 1'b0;

  logic  pv_hold = 1'b0;
  beat_t pv_beat;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, logic [TDA-1:0] act, logic [TDA-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Reference: group flits into beats by count or tail, flit 0 in LSBs
  task automatic model_flit(logic [FW-1:0] d, logic [TDW-1:0] t, logic tl);
    beat_t b;
    if (cur_n == 0) cur_t = t;
    cur_d = cur_d | (TDA'(d) << (cur_n * FW));
    cur_n++;
    if (cur_n == SF || tl) begin
      b.d = cur_d;
      b.t = cur_t;
      b.l = tl;
      expq.push_back(b);
      cur_d = '0;
      cur_n = 0;
    end
  endtask

  task automatic model_clear();
    expq.delete();
    cur_d = '0;
    cur_n = 0;
  endtask

  task automatic idle(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the flit was sampled
  task automatic send(logic [FW-1:0] d, logic [TDW-1:0] t, logic tl,
                      bit use_credit, bit modelled);
    int w;
    w = 0;
    if (use_credit) begin
      while (credits == 0 && w < 200) begin
        idle(1);
        w++;
      end
      chk("credit_wait", 512'(credits > 0), 512'(1));
      if (credits == 0) return;
      credits--;
    end
    data_in    = d;
    dest_in    = t;
    is_tail_in = tl;
    send_in    = 1'b1;
    if (modelled) model_flit(d, t, tl);
    idle(1);
    send_in = 1'b0;
  endtask

  task automatic chk_reset_outputs(string tag);
    chk({tag, "_tvalid"}, 512'(axis_tvalid), '0);
    chk({tag, "_tlast"}, 512'(axis_tlast), '0);
    chk({tag, "_tdata"}, axis_tdata, '0);
    chk({tag, "_tdest"}, 512'(axis_tdest), '0);
    chk({tag, "_credit"}, 512'(credit_out), '0);
    chk({tag, "_err"}, 512'(err_overflow), '0);
  endtask

  always @(negedge clk) begin
    beat_t e;
    beat_t g;
    if (!rst) begin
      if (credit_out) begin
        credits++;
        cred_cnt++;
        if (first_cred < 0) first_cred = cyc;
      end
      if (axis_tvalid && first_val < 0) first_val = cyc;
      chk("err_overflow", 512'(err_overflow), 512'(exp_err));
      g.d = axis_tdata;
      g.t = axis_tdest;
      g.l = axis_tlast;
      if (pv_hold) begin
        chk("hold_valid", 512'(axis_tvalid), 512'(1));
        chk("hold_beat", 512'(g), 512'(pv_beat));
      end
      if (axis_tvalid && axis_tready) begin
        chk("beat_expected", 512'(expq.size() != 0), 512'(1));
        if (expq.size() != 0) begin
          e = expq.pop_front();
          chk("tdata", axis_tdata, e.d);
          chk("tdest", 512'(axis_tdest), 512'(e.t));
          chk("tlast", 512'(axis_tlast), 512'(e.l));
        end
        rx_log.push_back(g);
      end
      pv_hold = axis_tvalid && !axis_tready;
      pv_beat = g;
    end else begin
      pv_hold = 1'b0;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode != 0) axis_tready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    int n0;
    int t0;
    int nb;
    int w;
    logic [FW-1:0] d;

    idle(2);
    rst = 1'b0;
    chk_reset_outputs("rst0");

    // Single 4-flit packet, back-to-back, ready high
    axis_tready = 1'b1;
    first_cred = -1;
    first_val  = -1;
    cred_cnt   = 0;
    n0 = cyc;
    send(FW'(8'h11), 6'd5, 1'b0, 1, 1);
    send(FW'(8'h22), 6'd9, 1'b0, 1, 1);
    send(FW'(8'h33), 6'd9, 1'b0, 1, 1);
    send(FW'(8'h44), 6'd9, 1'b1, 1, 1);
    idle(6);
    chk("first_credit_cyc", 512'(first_cred), 512'(n0 + 2));
    chk("first_valid_cyc", 512'(first_val), 512'(n0 + SF + 1));
    chk("pkt1_credits", 512'(cred_cnt), 512'(4));
    chk("pkt1_beats", 512'(rx_log.size()), 512'(1));
    chk("pkt1_data", rx_log[rx_log.size()-1].d,
        {128'h44, 128'h33, 128'h22, 128'h11});
    chk("pkt1_dest", 512'(rx_log[rx_log.size()-1].t), 512'(5));
    chk("pkt1_last", 512'(rx_log[rx_log.size()-1].l), 512'(1));

    // Short beat (tail on flit 2), then a full packet
    send(FW'(8'h55), 6'd3, 1'b0, 1, 1);
    send(FW'(8'h66), 6'd1, 1'b0, 1, 1);
    send(FW'(8'h77), 6'd1, 1'b1, 1, 1);
    send(FW'(8'h88), 6'd7, 1'b0, 1, 1);
    send(FW'(8'h99), 6'd7, 1'b0, 1, 1);
    send(FW'(8'haa), 6'd7, 1'b0, 1, 1);
    send(FW'(8'hbb), 6'd7, 1'b1, 1, 1);
    idle(8);
    chk("short_data", rx_log[rx_log.size()-2].d,
        {128'h0, 128'h77, 128'h66, 128'h55});
    chk("short_dest", 512'(rx_log[rx_log.size()-2].t), 512'(3));
    chk("short_last", 512'(rx_log[rx_log.size()-2].l), 512'(1));
    chk("next_data", rx_log[rx_log.size()-1].d,
        {128'hbb, 128'haa, 128'h99, 128'h88});

    // Output stalled for 20 cycles while 8 flits arrive
    axis_tready = 1'b0;
    cred_cnt = 0;
    t0 = cyc;
    for (int i = 0; i < 8; i++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      send(d, 6'(i), 1'b0, 1, 1);
    end
    if (cyc - t0 < 20) idle(20 - (cyc - t0));
    chk("stall_credits", 512'(cred_cnt), 512'(7));
    chk("stall_valid", 512'(axis_tvalid), 512'(1));
    nb = rx_log.size();
    axis_tready = 1'b1;
    @(negedge clk);
    chk("nobubble_v0", 512'(axis_tvalid), 512'(1));
    @(negedge clk);
    chk("nobubble_v1", 512'(axis_tvalid), 512'(1));
    @(posedge clk);
    #1;
    idle(4);
    chk("stall_beats", 512'(rx_log.size() - nb), 512'(2));
    chk("stall_credits_all", 512'(cred_cnt), 512'(8));

    // Random traffic with random backpressure
    cred_cnt = 0;
    rdy_mode = 1;
    for (int i = 0; i < 1000; i++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      send(d, 6'($urandom), (i == 999) || ($urandom_range(0, 3) == 0),
           1, 1);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    rdy_mode = 0;
    axis_tready = 1'b1;
    w = 0;
    while (expq.size() != 0 && w < 100) begin
      idle(1);
      w++;
    end
    idle(4);
    chk("rand_drain", 512'(expq.size()), '0);
    chk("rand_credit_total", 512'(cred_cnt), 512'(1000));

    // Reset mid-packet with flits in flight; send during reset ignored
    send(FW'(16'hdead), 6'd4, 1'b0, 1, 1);
    send(FW'(16'hbeef), 6'd4, 1'b0, 1, 1);
    send(FW'(16'hcafe), 6'd4, 1'b0, 1, 1);
    rst = 1'b1;
    data_in = FW'(16'hf00d);
    dest_in = 6'd8;
    is_tail_in = 1'b1;
    send_in = 1'b1;
    model_clear();
    idle(1);
    rst = 1'b0;
    send_in = 1'b0;
    credits = DEPTH;
    chk_reset_outputs("rst1");
    cred_cnt = 0;
    nb = rx_log.size();
    send(FW'(8'ha1), 6'd2, 1'b0, 1, 1);
    send(FW'(8'ha2), 6'd2, 1'b1, 1, 1);
    idle(6);
    chk("post_rst_beats", 512'(rx_log.size() - nb), 512'(1));
    chk("post_rst_data", rx_log[rx_log.size()-1].d,
        {128'h0, 128'h0, 128'ha2, 128'ha1});
    chk("post_rst_credits", 512'(cred_cnt), 512'(2));

`ifdef NOC_DESER_OVERFLOW_CHECK_EN
    // Fill FIFO behind a held beat, then push one flit too many
    axis_tready = 1'b0;
    for (int i = 0; i < 8; i++) send(FW'(i + 1), 6'd6, 1'b0, 1, 1);
    send(FW'(8'h09), 6'd6, 1'b0, 0, 1);
    send(FW'(8'h0a), 6'd6, 1'b0, 0, 1);
    send(FW'(8'h0b), 6'd6, 1'b1, 0, 1);
    send(FW'(8'h0c), 6'd6, 1'b1, 0, 0);
    exp_err = 1'b1;
    idle(4);
    axis_tready = 1'b1;
    idle(15);
    chk("ovf_drain", 512'(expq.size()), '0);
    chk("ovf_flag", 512'(err_overflow), 512'(1));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got %0d cycles want completion", cyc);
    $fatal(1, "timeout");
  end

endmodule
